// File: rtl/regs_master.sv
// Register-file req/ack initiator: takes core commands, runs a four-phase handshake, returns operands or error.
// Latency: SETUP_CYCLES + 2*(SYNC_STAGES+1) cycles from acceptance to rsp_valid (7 at defaults); 1 cycle when nothing to do.
// Backpressure: cmd_ready only in IDLE with ack_sync low; the response is held in RESP until rsp_ready.
//
// Ports:
//   clk, reset_n                  - clock and synchronous active-low reset
//   cmd_*                         - command channel (valid/ready), read/write flags, indices, write data
//   rsp_*                         - response channel (valid/ready), captured operands, timeout error
//   req / ack                     - four-phase handshake to the register file (ack is asynchronous)
//   rs_read_n, rd_write_n         - active-low strobes to the register file
//   rs1, rs2, rd, rd_value        - address/data to the register file
//   rs1_value, rs2_value          - read data from the register file
module regs_master #(
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_rs1,
    input  logic [4:0]  cmd_rs2,
    input  logic [4:0]  cmd_rd,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rs1_value,
    output logic [31:0] rsp_rs2_value,
    output logic        rsp_error,
    output logic        req,
    input  logic        ack,
    output logic        rs_read_n,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        rd_write_n,
    output logic [31:0] rd_value,
    input  logic [31:0] rs1_value,
    input  logic [31:0] rs2_value
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        REQ     = 3'd2,
        RELEASE = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [7:0] SETUP_LAST   = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   req_q, req_d;
    logic                   rs_read_n_q, rs_read_n_d;
    logic                   rd_write_n_q, rd_write_n_d;
    logic [4:0]             rs1_q, rs1_d;
    logic [4:0]             rs2_q, rs2_d;
    logic [4:0]             rd_q, rd_d;
    logic [31:0]            rd_value_q, rd_value_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_error_q, rsp_error_d;
    logic [31:0]            rsp_rs1_q, rsp_rs1_d;
    logic [31:0]            rsp_rs2_q, rsp_rs2_d;

    logic ack_sync;
    logic acc_read_n;
    logic acc_write_n;

    assign ack_sync    = sync_q[SYNC_STAGES-1];
    // Strobe values an accepted command would drive; a write to x0 is dropped here.
    assign acc_read_n  = !cmd_read;
    assign acc_write_n = !(cmd_write && (cmd_rd != 5'd0));

    always_comb begin
        state_d      = state_q;
        sync_d       = {sync_q[SYNC_STAGES-2:0], ack};
        cnt_d        = cnt_q;
        req_d        = req_q;
        rs_read_n_d  = rs_read_n_q;
        rd_write_n_d = rd_write_n_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        rd_value_d   = rd_value_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_error_d  = rsp_error_q;
        rsp_rs1_d    = rsp_rs1_q;
        rsp_rs2_d    = rsp_rs2_q;

        case (state_q)
            IDLE: begin
                // cmd_ready_q already equals (IDLE && !ack_sync) this cycle.
                if (cmd_valid && cmd_ready_q) begin
                    rs1_d        = cmd_rs1;
                    rs2_d        = cmd_rs2;
                    rd_d         = cmd_rd;
                    rd_value_d   = cmd_wdata;
                    rs_read_n_d  = acc_read_n;
                    rd_write_n_d = acc_write_n;
                    cnt_d        = 8'd0;
                    if (acc_read_n && acc_write_n) begin
                        // Nothing left to do: answer at once without touching req.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b0;
                        rsp_rs1_d   = 32'd0;
                        rsp_rs2_d   = 32'd0;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end

            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            REQ: begin
                if (ack_sync) begin
                    if (!rs_read_n_q) begin
                        rsp_rs1_d = rs1_value;
                        rsp_rs2_d = rs2_value;
                    end
                    req_d   = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = RELEASE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    req_d        = 1'b0;
                    rsp_error_d  = 1'b1;
                    rsp_rs1_d    = 32'd0;
                    rsp_rs2_d    = 32'd0;
                    rs_read_n_d  = 1'b1;
                    rd_write_n_d = 1'b1;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            RELEASE: begin
                if (!ack_sync) begin
                    rs_read_n_d  = 1'b1;
                    rd_write_n_d = 1'b1;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Values captured at ack are discarded: an error carries zero operands.
                    rsp_error_d  = 1'b1;
                    rsp_rs1_d    = 32'd0;
                    rsp_rs2_d    = 32'd0;
                    rs_read_n_d  = 1'b1;
                    rd_write_n_d = 1'b1;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_error_d = 1'b0;
                    cnt_d       = 8'd0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered form of (state==IDLE && !ack_sync), built from next-state values.
        cmd_ready_d = (state_d == IDLE) && !sync_d[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            cnt_q        <= 8'd0;
            cmd_ready_q  <= 1'b1;
            req_q        <= 1'b0;
            rs_read_n_q  <= 1'b1;
            rd_write_n_q <= 1'b1;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rd_q         <= 5'd0;
            rd_value_q   <= 32'd0;
            rsp_valid_q  <= 1'b0;
            rsp_error_q  <= 1'b0;
            rsp_rs1_q    <= 32'd0;
            rsp_rs2_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            req_q        <= req_d;
            rs_read_n_q  <= rs_read_n_d;
            rd_write_n_q <= rd_write_n_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            rd_value_q   <= rd_value_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_error_q  <= rsp_error_d;
            rsp_rs1_q    <= rsp_rs1_d;
            rsp_rs2_q    <= rsp_rs2_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign req           = req_q;
    assign rs_read_n     = rs_read_n_q;
    assign rd_write_n    = rd_write_n_q;
    assign rs1           = rs1_q;
    assign rs2           = rs2_q;
    assign rd            = rd_q;
    assign rd_value      = rd_value_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_error     = rsp_error_q;
    assign rsp_rs1_value = rsp_rs1_q;
    assign rsp_rs2_value = rsp_rs2_q;

endmodule

// File: tb/tb_regs_master.sv
// Directed bench for regs_master with a behavioural register file whose ack follows req.
// Latency: measured in clk edges from the acceptance edge to the first cycle rsp_valid is high.
// Backpressure: rsp_ready held low for a window to check the response stays put.
module tb_regs_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_read = 1'b0;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_rs1 = 5'd0;
    logic [4:0]  cmd_rs2 = 5'd0;
    logic [4:0]  cmd_rd = 5'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rs1_value;
    logic [31:0] rsp_rs2_value;
    logic        rsp_error;
    logic        req;
    logic        ack;
    logic        rs_read_n;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_write_n;
    logic [31:0] rd_value;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;

    logic        ack_dead = 1'b0;
    logic        stuck_hi = 1'b0;
    logic [31:0] regs [32];
    int          req_rises = 0;
    int          checks = 0;
    int          errors = 0;

    regs_master #(
        .SYNC_STAGES (2),
        .SETUP_CYCLES(1),
        .TIMEOUT     (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_read     (cmd_read),
        .cmd_write    (cmd_write),
        .cmd_rs1      (cmd_rs1),
        .cmd_rs2      (cmd_rs2),
        .cmd_rd       (cmd_rd),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rs1_value(rsp_rs1_value),
        .rsp_rs2_value(rsp_rs2_value),
        .rsp_error    (rsp_error),
        .req          (req),
        .ack          (ack),
        .rs_read_n    (rs_read_n),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .rd_write_n   (rd_write_n),
        .rd_value     (rd_value),
        .rs1_value    (rs1_value),
        .rs2_value    (rs2_value)
    );

    always #5 clk = ~clk;

    // Responder: ack mirrors req unless forced dead or stuck high.
    assign ack       = stuck_hi | (req & !ack_dead);
    assign rs1_value = regs[rs1];
    assign rs2_value = regs[rs2];

    // Register file contents and the write it takes on each req rising edge.
    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[3] = 32'h11223344;
        regs[7] = 32'hA5A5A5A5;
        forever begin
            @(posedge req);
            req_rises++;
            if (!rd_write_n && rd != 5'd0) regs[rd] = rd_value;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the acceptance edge.
    task automatic send(input logic rd_en, input logic wr_en, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] ad, input logic [31:0] wd);
        bit seen = 0;
        cmd_read  = rd_en;
        cmd_write = wr_en;
        cmd_rs1   = a1;
        cmd_rs2   = a2;
        cmd_rd    = ad;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                seen = 1;
                break;
            end
        end
        chk("cmd_accept", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Edges until rsp_valid is seen, and how many of those sampled cycles had req high.
    task automatic wait_rsp(output int lat, output int req_hi);
        lat = 0;
        req_hi = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (req) req_hi++;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    int lat;
    int hi;
    int rises0;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_rs_read_n", 32'(rs_read_n), 32'd1);
        chk("rst_rd_write_n", 32'(rd_write_n), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        chk("rst_addr", {17'd0, rs1, rs2, rd}, 32'd0);
        chk("rst_rd_value", rd_value, 32'd0);
        chk("rst_rsp_rs1", rsp_rs1_value, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Plain read of x3/x7
        rises0 = req_rises;
        send(1'b1, 1'b0, 5'd3, 5'd7, 5'd0, 32'd0);
        chk("rd_rs_read_n", 32'(rs_read_n), 32'd0);
        chk("rd_rd_write_n", 32'(rd_write_n), 32'd1);
        chk("rd_cmd_ready", 32'(cmd_ready), 32'd0);
        wait_rsp(lat, hi);
        chk("rd_latency", 32'(lat), 32'd7);
        chk("rd_rs1", rsp_rs1_value, 32'h11223344);
        chk("rd_rs2", rsp_rs2_value, 32'hA5A5A5A5);
        chk("rd_error", 32'(rsp_error), 32'd0);
        chk("rd_req_pulses", 32'(req_rises - rises0), 32'd1);
        chk("rd_strobe_idle", 32'(rs_read_n), 32'd1);
        take_rsp();
        chk("rd_done_valid", 32'(rsp_valid), 32'd0);

        // Write x5 then read it back
        send(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF);
        chk("wr_rd_write_n", 32'(rd_write_n), 32'd0);
        chk("wr_rd_value", rd_value, 32'hDEADBEEF);
        wait_rsp(lat, hi);
        chk("wr_latency", 32'(lat), 32'd7);
        chk("wr_error", 32'(rsp_error), 32'd0);
        take_rsp();
        send(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'd0);
        wait_rsp(lat, hi);
        chk("wr_rb_rs1", rsp_rs1_value, 32'hDEADBEEF);
        chk("wr_rb_rs2", rsp_rs2_value, 32'd0);
        take_rsp();

        // Write to x0 is dropped and no handshake runs
        rises0 = req_rises;
        send(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h00001234);
        // rsp_valid already high in the cycle right after the acceptance edge
        chk("x0_valid", 32'(rsp_valid), 32'd1);
        chk("x0_rd_write_n", 32'(rd_write_n), 32'd1);
        chk("x0_rs1", rsp_rs1_value, 32'd0);
        chk("x0_rs2", rsp_rs2_value, 32'd0);
        chk("x0_error", 32'(rsp_error), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("x0_no_req", 32'(req_rises - rises0), 32'd0);
        take_rsp();

        // Timeout in REQ: no ack ever
        ack_dead = 1'b1;
        send(1'b1, 1'b0, 5'd3, 5'd7, 5'd0, 32'd0);
        wait_rsp(lat, hi);
        chk("to_req_latency", 32'(lat), 32'd9);
        chk("to_req_hi_cycles", 32'(hi), 32'd8);
        chk("to_req_drop", 32'(req), 32'd0);
        chk("to_req_error", 32'(rsp_error), 32'd1);
        chk("to_req_rs1", rsp_rs1_value, 32'd0);
        chk("to_req_rs2", rsp_rs2_value, 32'd0);
        chk("to_req_strobe", 32'(rs_read_n), 32'd1);
        take_rsp();
        ack_dead = 1'b0;

        // Timeout in RELEASE: ack stays high after req falls
        send(1'b1, 1'b0, 5'd3, 5'd7, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        stuck_hi = 1'b1;
        wait_rsp(lat, hi);
        chk("to_rel_latency", 32'(lat + 1), 32'd12);
        chk("to_rel_error", 32'(rsp_error), 32'd1);
        chk("to_rel_rs1", rsp_rs1_value, 32'd0);
        chk("to_rel_rs2", rsp_rs2_value, 32'd0);
        take_rsp();
        chk("to_rel_ready_lo0", 32'(cmd_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("to_rel_ready_lo1", 32'(cmd_ready), 32'd0);
        stuck_hi = 1'b0;
        @(posedge clk);
        #1;
        chk("to_rel_ready_lo2", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("to_rel_ready_hi", 32'(cmd_ready), 32'd1);

        // Response backpressure
        send(1'b1, 1'b0, 5'd7, 5'd3, 5'd0, 32'd0);
        wait_rsp(lat, hi);
        chk("bp_latency", 32'(lat), 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rs1", rsp_rs1_value, 32'hA5A5A5A5);
            chk("bp_rs2", rsp_rs2_value, 32'h11223344);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        take_rsp();
        chk("bp_done_valid", 32'(rsp_valid), 32'd0);
        chk("bp_done_ready", 32'(cmd_ready), 32'd1);
        chk("bp_keep_rs1", rsp_rs1_value, 32'hA5A5A5A5);

        // Reset while req is high
        send(1'b1, 1'b0, 5'd3, 5'd7, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        chk("mr_req_hi", 32'(req), 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("mr_req_lo", 32'(req), 32'd0);
        chk("mr_valid_lo", 32'(rsp_valid), 32'd0);
        chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        send(1'b1, 1'b0, 5'd7, 5'd3, 5'd0, 32'd0);
        wait_rsp(lat, hi);
        chk("mr_latency", 32'(lat), 32'd7);
        chk("mr_rs1", rsp_rs1_value, 32'hA5A5A5A5);
        chk("mr_rs2", rsp_rs2_value, 32'h11223344);
        chk("mr_error", 32'(rsp_error), 32'd0);
        take_rsp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regs_master.md
Name: regs_master

Overview:
Initiator for the register-file req/ack access protocol. It accepts decoded register-access commands from the core over a valid/ready interface and drives the register file's address, data and active-low read/write strobes. It runs a four-phase req/ack handshake with an ack synchronizer and a timeout. It then returns the read operands, or an error, over a valid/ready response interface.

Parameters:
SYNC_STAGES, 2, number of flops synchronizing ack into clk domain (min 2)
SETUP_CYCLES, 1, cycles address/data/strobes are held stable before req rises (min 1)
TIMEOUT, 255, max cycles waited in REQ or RELEASE before declaring error (8-bit counter, min 4)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  synchronous reset, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when valid&ready
cmd_read  input  1  read rs1/rs2
cmd_write  input  1  write rd
cmd_rs1  input  5  source 1 index
cmd_rs2  input  5  source 2 index
cmd_rd  input  5  destination index
cmd_wdata  input  32  write data
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when valid&ready
rsp_rs1_value  output  32  captured rs1 value
rsp_rs2_value  output  32  captured rs2 value
rsp_error  output  1  handshake timed out
req  output  1  handshake request to register file
ack  input  1  handshake acknowledge, asynchronous to clk
rs_read_n  output  1  active-low read strobe
rs1  output  5  to register file
rs2  output  5  to register file
rd  output  5  to register file
rd_write_n  output  1  active-low write strobe
rd_value  output  32  to register file
rs1_value  input  32  from register file
rs2_value  input  32  from register file

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset_n=0 at a clk edge): state IDLE; req=0, rs_read_n=1, rd_write_n=1, rs1/rs2/rd=0, rd_value=0, rsp_valid=0, rsp_error=0, rsp values=0, sync chain=0, timeout counter=0. Mid-handshake reset drops req immediately. Any write already taken by the register file stands.
- ack_sync = ack through SYNC_STAGES flops. The FSM uses only ack_sync.
- All outputs are registered.
- cmd_ready = (state==IDLE) && !ack_sync. A new handshake never starts while the previous ack is still high.
- Acceptance edge:
  - Latch rs1/rs2/rd/rd_value from cmd.
  - rs_read_n = !cmd_read.
  - rd_write_n = !(cmd_write && cmd_rd!=0). Writes to x0 are suppressed.
- Fast path: if after suppression neither read nor write remains, go directly to RESP with values 0 and error 0, and return strobes to inactive. No req is issued.
- States:
  - IDLE: waits for command acceptance.
  - SETUP: req=0; stays SETUP_CYCLES cycles, then goes to REQ with req<=1.
  - REQ: counter increments each cycle.
    - On ack_sync=1: if reading, capture rs1_value/rs2_value into rsp regs; req<=0; counter cleared; go to RELEASE.
    - On counter==TIMEOUT-1 with no ack_sync: req<=0, rsp_error<=1, go to RESP.
  - RELEASE: req=0; counter increments.
    - On ack_sync=0: strobes return inactive; go to RESP.
    - On timeout: rsp_error<=1, go to RESP.
  - RESP: rsp_valid=1. Payload is held stable until rsp_ready. The cycle of valid&ready goes to IDLE, and rsp_valid, rsp_error and the counter are cleared. Read values stay until overwritten.
- Addresses, data and strobes are stable from acceptance through RELEASE exit.
- On error, rsp values are 0.
- Latency with a responder where ack follows req combinationally: rsp_valid first high SETUP_CYCLES + 2*(SYNC_STAGES+1) cycles after the acceptance edge (7 at defaults). Fast path latency is 1 cycle.
- Simultaneous read and write: one handshake. Captured read values are whatever the register file drives at ack. Read-during-write ordering is owned by the register file.

Test Plan:
- Read: regfile x3=0x11223344, x7=0xA5A5A5A5; cmd_read=1, rs1=3, rs2=7 -> req pulses once, rs_read_n=0, rd_write_n=1; rsp_valid 7 cycles after acceptance with 0x11223344/0xA5A5A5A5, rsp_error=0.
- Write then read: write rd=5, wdata=0xDEADBEEF; then read rs1=5 -> first rsp has error=0; second rsp rs1 value=0xDEADBEEF.
- x0 suppression: cmd_write=1, rd=0, cmd_read=0 -> no req edge, rd_write_n stays 1, rsp_valid 1 cycle after accept, values 0.
- Timeout: ack tied 0, TIMEOUT=8 -> req drops after 8 REQ cycles; rsp_valid=1, rsp_error=1, values 0. Repeat with ack stuck at 1 -> error from RELEASE; cmd_ready stays 0 until ack falls.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and payload stable; cmd_ready=0 throughout; completes on first ready cycle.
- Reset mid-REQ: reset_n=0 one cycle while req=1 -> next cycle req=0, rsp_valid=0, state IDLE; a following read completes normally.
